cmps_repne_sequencer_ex: RTL and testbench
==========================================

// Module: cmps_repne_sequencer_ex
// PURPOSE
//  Sequences CMPS / REPNE CMPS micro-ops through the EX stage.
//  - Drives the first/second-uop selects and the internal-count select into the EX operand/result muxes.
//  - Keeps the live REPNE count and decides loop termination.
//  - Holds the upstream pipeline while a string loop is in flight. Sits beside the EX-stage datapath, before the WB latches.
// PARAMETERS
//  CNT_W      32  width of count register (ECX)
//  ITER_LIMIT 0   watchdog: force terminate after this many iterations; 0 = disabled
// PORTS
//  CLK                         in  1      clock, rising edge
//  CLR                         in  1      reset, asynchronous, active-low
//  EX_V                        in  1      EX latch valid
//  ex_flush                    in  1      pipeline flush (branch/exception); aborts sequence
//  WB_Stall                    in  1      WB cannot accept; freezes sequencer
//  CS_IS_CMPS_EX               in  1      EX instruction is CMPS
//  WB_de_repne_all             in  1      instruction carries REPNE prefix
//  EX_C                        in  CNT_W  architectural count at sequence start
//  count_minus_one             in  CNT_W  datapath count-1 (of selected count)
//  alu_zf                      in  1      alu32_flags[6] of current compare
//  CS_IS_CMPS_FIRST_UOP_ALL    out 1      first uop active (latch src operand)
//  CS_IS_CMPS_SECOND_UOP_ALL   out 1      second uop active (compare)
//  CS_REPNE_INTERNAL_COUNT_WB  out 1      datapath uses saved_count instead of EX_C
//  saved_count                 out CNT_W  live iteration count
//  wb_repne_terminate_all      out 1      current second uop is last iteration
//  ex_hold                     out 1      hold EX/upstream latches (sequence busy)
//  seq_busy                    out 1      state != IDLE
// BEHAVIOUR
//  Reset (CLR=0, async): state=IDLE, saved_count=0, iter=0, all outputs 0.
//  States: IDLE, FIRST, SECOND, ZTERM. Outputs decoded from registered state (Moore), except wb_repne_terminate_all (Mealy in SECOND).
//  start = EX_V & CS_IS_CMPS_EX & ~WB_Stall & ~ex_flush, in IDLE only.
//  IDLE: on start, saved_count<=EX_C, iter<=0.
//    If WB_de_repne_all & EX_C==0, go ZTERM. Else go FIRST.
//  FIRST: FIRST_UOP=1, ex_hold=1, REPNE_INTERNAL_COUNT=(iter!=0). Go SECOND when ~WB_Stall.
//  SECOND: SECOND_UOP=1, REPNE_INTERNAL_COUNT=1.
//    term = ~WB_de_repne_all | alu_zf | (count_minus_one==0) | (ITER_LIMIT!=0 & iter+1==ITER_LIMIT).
//    wb_repne_terminate_all=term.
//    ex_hold=~term (on the completing edge EX releases).
//    When ~WB_Stall: saved_count<=count_minus_one, iter<=iter+1. Go IDLE if term, else go FIRST.
//  ZTERM: one cycle with wb_repne_terminate_all=1, no uop select, ex_hold=0. WB drops it (zero-count REPNE = no-op). Go IDLE.
//  WB_Stall=1: state, saved_count, iter frozen; outputs held stable.
//  ex_flush=1 (any state): next state IDLE, saved_count retained, terminate not asserted. Flush has priority over WB_Stall.
//  Non-REPNE CMPS: exactly FIRST then SECOND (2 cycles min), saved_count decremented once, unused.
//  Count arithmetic is modulo 2^CNT_W. count_minus_one is supplied by the datapath; the block performs no subtraction of its own except iter+1.
//  Latency: start->FIRST 1 cycle; each iteration 2 cycles absent stalls.
// STRUCTURE
//  Package ex_seq_pkg: state encodings (IDLE=2'b00, FIRST=2'b01, SECOND=2'b10, ZTERM=2'b11) and CNT_W default.
//  Sub-module count_reg_ex: CNT_W enabled register with load (EX_C) / update (count_minus_one) select and ==0 detect.
//  The rest is the FSM plus the iter counter in this module.
// TESTING
//  1. Reset mid-SECOND (CLR low 1 cycle) -> all outputs 0 asynchronously, state IDLE; next start behaves normally.
//  2. Plain CMPS, EX_C=5 -> FIRST 1 cycle, SECOND 1 cycle, terminate=1 in SECOND, saved_count=4, ex_hold low after.
//  3. REPNE CMPS, EX_C=3, alu_zf=0 always -> 3 FIRST/SECOND pairs; terminate only in 3rd SECOND; saved_count 2,1,0.
//  4. REPNE, EX_C=10, alu_zf=1 on 2nd compare -> terminate in 2nd SECOND, saved_count=8, IDLE next.
//  5. REPNE, EX_C=0 -> ZTERM one cycle with terminate=1, no uop selects; saved_count=0.
//  6. WB_Stall held 3 cycles during SECOND, then ex_flush during FIRST -> outputs frozen 3 cycles, then IDLE next cycle with no terminate.

Source files
------------

// File: rtl/cmps_repne_sequencer_ex_pkg.sv
// Shared definitions for the CMPS / REPNE CMPS EX-stage sequencer.
package ex_seq_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10,
    ZTERM  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/cmps_repne_sequencer_ex_if.sv
// Handshake and datapath bundle between the EX stage and the CMPS sequencer.
interface cmps_repne_sequencer_ex_if
  import ex_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             EX_V;
  logic             ex_flush;
  logic             WB_Stall;
  logic             CS_IS_CMPS_EX;
  logic             WB_de_repne_all;
  logic [CNT_W-1:0] EX_C;
  logic [CNT_W-1:0] count_minus_one;
  logic             alu_zf;

  logic             CS_IS_CMPS_FIRST_UOP_ALL;
  logic             CS_IS_CMPS_SECOND_UOP_ALL;
  logic             CS_REPNE_INTERNAL_COUNT_WB;
  logic [CNT_W-1:0] saved_count;
  logic             wb_repne_terminate_all;
  logic             ex_hold;
  logic             seq_busy;

  // The pipeline side drives the controls and observes the selects.
  modport master (
    output EX_V, ex_flush, WB_Stall, CS_IS_CMPS_EX, WB_de_repne_all,
           EX_C, count_minus_one, alu_zf,
    input  CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL,
           CS_REPNE_INTERNAL_COUNT_WB, saved_count, wb_repne_terminate_all,
           ex_hold, seq_busy
  );

  modport slave (
    input  EX_V, ex_flush, WB_Stall, CS_IS_CMPS_EX, WB_de_repne_all,
           EX_C, count_minus_one, alu_zf,
    output CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL,
           CS_REPNE_INTERNAL_COUNT_WB, saved_count, wb_repne_terminate_all,
           ex_hold, seq_busy
  );
endinterface

// File: rtl/cmps_repne_sequencer_ex_count_reg.sv
// Live REPNE count register: loads the architectural count or the datapath
// count-1, and flags whether the selected next value is zero.
module count_reg_ex
  import ex_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_sel_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] upd_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             next_zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] next_val;

  assign next_val    = load_sel_i ? load_val_i : upd_val_i;
  assign next_zero_o = (next_val == '0);
  assign count_d     = en_i ? next_val : count_q;
  assign count_o     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/cmps_repne_sequencer_ex.sv
// CMPS / REPNE CMPS micro-op sequencer for the EX stage: uop selects,
// live iteration count, loop termination and upstream hold.
module cmps_repne_sequencer_ex
  import ex_seq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int ITER_LIMIT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cmps_repne_sequencer_ex_if.slave   bus
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] iter_plus_one;

  logic cnt_en;
  logic cnt_load_sel;
  logic cnt_zero;
  logic start;
  logic iter_limit_hit;
  logic term;

  logic first_uop;
  logic second_uop;
  logic internal_cnt;
  logic term_out;
  logic hold;

  count_reg_ex #(.CNT_W(CNT_W)) u_count (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (cnt_en),
    .load_sel_i  (cnt_load_sel),
    .load_val_i  (bus.EX_C),
    .upd_val_i   (bus.count_minus_one),
    .count_o     (bus.saved_count),
    .next_zero_o (cnt_zero)
  );

  assign start          = bus.EX_V & bus.CS_IS_CMPS_EX & ~bus.WB_Stall & ~bus.ex_flush;
  assign iter_plus_one  = iter_q + 1'b1;
  assign iter_limit_hit = (ITER_LIMIT != 0) && (iter_plus_one == CNT_W'(ITER_LIMIT));
  // In IDLE the zero detect looks at EX_C, otherwise at count_minus_one.
  assign cnt_load_sel   = (state_q == IDLE);
  assign term           = ~bus.WB_de_repne_all | bus.alu_zf | cnt_zero | iter_limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    cnt_en       = 1'b0;
    first_uop    = 1'b0;
    second_uop   = 1'b0;
    internal_cnt = 1'b0;
    term_out     = 1'b0;
    hold         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_en  = 1'b1;
          iter_d  = '0;
          state_d = (bus.WB_de_repne_all && cnt_zero) ? ZTERM : FIRST;
        end
      end
      FIRST: begin
        first_uop    = 1'b1;
        hold         = 1'b1;
        internal_cnt = (iter_q != '0);
        if (!bus.WB_Stall) state_d = SECOND;
      end
      SECOND: begin
        second_uop   = 1'b1;
        internal_cnt = 1'b1;
        term_out     = term;
        hold         = ~term;
        if (!bus.WB_Stall) begin
          cnt_en  = 1'b1;
          iter_d  = iter_plus_one;
          state_d = term ? IDLE : FIRST;
        end
      end
      ZTERM: begin
        term_out = 1'b1;
        if (!bus.WB_Stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons the sequence without committing a count update.
    if (bus.ex_flush) begin
      state_d  = IDLE;
      cnt_en   = 1'b0;
      iter_d   = iter_q;
      term_out = 1'b0;
    end
  end

  assign bus.CS_IS_CMPS_FIRST_UOP_ALL   = first_uop;
  assign bus.CS_IS_CMPS_SECOND_UOP_ALL  = second_uop;
  assign bus.CS_REPNE_INTERNAL_COUNT_WB = internal_cnt;
  assign bus.wb_repne_terminate_all     = term_out;
  assign bus.ex_hold                    = hold;
  assign bus.seq_busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_cmps_repne_sequencer_ex.sv
// Directed bench for cmps_repne_sequencer_ex with a count-1 datapath model.
module tb_cmps_repne_sequencer_ex;

  logic clk;
  logic rst_n;
  int   testCount = 0;
  int   failCount = 0;

  cmps_repne_sequencer_ex_if #(.CNT_W(32)) sq ();

  cmps_repne_sequencer_ex #(.CNT_W(32), .ITER_LIMIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sq.slave)
  );

  // Datapath: count-1 of whichever count the sequencer selects.
  assign sq.count_minus_one = sq.CS_REPNE_INTERNAL_COUNT_WB ? sq.saved_count - 32'd1
                                                            : sq.EX_C - 32'd1;

  // Bit order: first, second, internal, terminate, hold, busy.
  logic [5:0] obs;
  assign obs = {sq.CS_IS_CMPS_FIRST_UOP_ALL, sq.CS_IS_CMPS_SECOND_UOP_ALL,
                sq.CS_REPNE_INTERNAL_COUNT_WB, sq.wb_repne_terminate_all,
                sq.ex_hold, sq.seq_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  // Applies one cycle of stimulus after a rising edge; outputs settle by the falling edge.
  task automatic drive(input logic start, input logic repne, input logic [31:0] exc,
                       input logic zf, input logic stall, input logic flush);
    @(posedge clk);
    #1;
    sq.EX_V            = start;
    sq.CS_IS_CMPS_EX   = 1'b1;
    sq.WB_de_repne_all = repne;
    sq.EX_C            = exc;
    sq.alu_zf          = zf;
    sq.WB_Stall        = stall;
    sq.ex_flush        = flush;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sq.EX_V = 1'b0; sq.CS_IS_CMPS_EX = 1'b0; sq.WB_de_repne_all = 1'b0;
    sq.EX_C = '0; sq.alu_zf = 1'b0; sq.WB_Stall = 1'b0; sq.ex_flush = 1'b0;
    #12;
    testCount++;
    if (obs !== 6'b000000) begin
      failCount++;
      $display("[TB] FAIL reset_outputs got %b expected 000000", obs);
    end
    testCount++;
    if (sq.saved_count !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL reset_count got %0d expected 0", sq.saved_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_plain();
    logic [5:0]  expOut [4] = '{6'b000000, 6'b100011, 6'b011101, 6'b000000};
    logic [31:0] expCnt [4] = '{32'd0, 32'd5, 32'd5, 32'd4};
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL plain_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL plain_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  task automatic test_repne_count();
    logic [5:0]  expOut [8] = '{6'b000000, 6'b100011, 6'b011011, 6'b101011,
                                6'b011011, 6'b101011, 6'b011101, 6'b000000};
    logic [31:0] expCnt [8] = '{32'd4, 32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0};
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL repne3_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL repne3_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  task automatic test_repne_zf();
    logic [5:0]  expOut [6] = '{6'b000000, 6'b100011, 6'b011011, 6'b101011,
                                6'b011101, 6'b000000};
    logic [31:0] expCnt [6] = '{32'd0, 32'd10, 32'd10, 32'd9, 32'd9, 32'd8};
    logic [5:0]  zfSeq = 6'b010000;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 1'b1, 32'd10, zfSeq[i], 1'b0, 1'b0);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL zf_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL zf_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    logic [5:0]  expOut [3] = '{6'b000000, 6'b000101, 6'b000000};
    logic [31:0] expCnt [3] = '{32'd8, 32'd0, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL zero_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL zero_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [5:0]  expOut [8] = '{6'b000000, 6'b100011, 6'b011011, 6'b011011,
                                6'b011011, 6'b011011, 6'b101011, 6'b000000};
    logic [31:0] expCnt [8] = '{32'd0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd3, 32'd3};
    logic [7:0]  stallSeq = 8'b0001_1100;
    logic [7:0]  flushSeq = 8'b0100_0000;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, 32'd4, 1'b0, stallSeq[i], flushSeq[i]);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL stall_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL stall_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  task automatic test_flush_second();
    logic [5:0]  expOut [4] = '{6'b000000, 6'b100011, 6'b011001, 6'b000000};
    logic [31:0] expCnt [4] = '{32'd3, 32'd1, 32'd1, 32'd1};
    logic [3:0]  flushSeq = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b1, 32'd1, 1'b0, 1'b0, flushSeq[i]);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL flush2_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL flush2_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid_second();
    logic [5:0]  expOut [4] = '{6'b000000, 6'b100011, 6'b011101, 6'b000000};
    logic [31:0] expCnt [4] = '{32'd0, 32'd7, 32'd7, 32'd6};
    drive(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    testCount++;
    if (obs !== 6'b011101) begin
      failCount++;
      $display("[TB] FAIL midreset_pre got %b expected 011101", obs);
    end
    #1 rst_n = 1'b0;
    #1;
    testCount++;
    if (obs !== 6'b000000) begin
      failCount++;
      $display("[TB] FAIL midreset_async_out got %b expected 000000", obs);
    end
    testCount++;
    if (sq.saved_count !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL midreset_async_cnt got %0d expected 0", sq.saved_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);
      testCount++;
      if (obs !== expOut[i]) begin
        failCount++;
        $display("[TB] FAIL postreset_out[%0d] got %b expected %b", i, obs, expOut[i]);
      end
      testCount++;
      if (sq.saved_count !== expCnt[i]) begin
        failCount++;
        $display("[TB] FAIL postreset_cnt[%0d] got %0d expected %0d", i, sq.saved_count, expCnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_repne_count();
    test_repne_zf();
    test_zero_count();
    test_stall_flush();
    test_flush_second();
    test_reset_mid_second();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
